// File: rtl/fetch_sequencer.sv
// Instruction-cycle controller: fetches opcode/operands over req/ack,
// steers the program counter and strobes the accumulator/ALU datapath.
module fetch_sequencer #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  clear_n,
    input  logic [ADDR_WIDTH-1:0] pc_address,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack,
    input  logic                  zero_flag,
    input  logic                  carry_flag,
    input  logic                  resume,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  pc_clear,
    output logic                  pc_count,
    output logic                  pc_load,
    output logic [ADDR_WIDTH-1:0] jump_address,
    output logic [DATA_WIDTH-1:0] opcode,
    output logic                  alu_en,
    output logic                  acc_load,
    output logic                  acc_store,
    output logic                  illegal_op,
    output logic                  bus_error,
    output logic                  halted
);

    typedef enum logic [2:0] {
        S_RST, S_FETCH, S_DECODE, S_OPLO, S_OPHI, S_EXEC, S_HALT
    } state_t;

    // Counter only has to reach TIMEOUT-1; the limit edge itself trips.
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

    state_t state, state_next;
    logic [DATA_WIDTH-1:0] opnd_lo, opnd_hi;
    logic [CW-1:0] wait_cnt;
    logic [3:0] op_class;
    logic lat_op, lat_lo, lat_hi;
    logic timed_out;

    assign op_class = opcode[DATA_WIDTH-1 -: 4];
    assign jump_address = ADDR_WIDTH'({opnd_hi, opnd_lo});
    assign timed_out = mem_req && !mem_ack && (TIMEOUT > 0)
                       && (wait_cnt == LIMIT);

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            state     <= S_RST;
            opcode    <= '0;
            opnd_lo   <= '0;
            opnd_hi   <= '0;
            wait_cnt  <= '0;
            bus_error <= 1'b0;
        end else begin
            state <= state_next;
            if (lat_op) opcode  <= mem_rdata;
            if (lat_lo) opnd_lo <= mem_rdata;
            if (lat_hi) opnd_hi <= mem_rdata;
            if (!mem_req || mem_ack || state_next != state)
                wait_cnt <= '0;
            else
                wait_cnt <= wait_cnt + CW'(1);
            if (timed_out) bus_error <= 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = pc_address;
        pc_clear   = 1'b0;
        pc_count   = 1'b0;
        pc_load    = 1'b0;
        alu_en     = 1'b0;
        acc_load   = 1'b0;
        acc_store  = 1'b0;
        illegal_op = 1'b0;
        halted     = 1'b0;
        lat_op     = 1'b0;
        lat_lo     = 1'b0;
        lat_hi     = 1'b0;
        unique case (state)
            S_RST: begin
                pc_clear   = 1'b1;
                state_next = S_FETCH;
            end
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    pc_count   = 1'b1;
                    lat_op     = 1'b1;
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                case (op_class)
                    4'h1, 4'h2, 4'h4, 4'h5, 4'h6: state_next = S_OPLO;
                    4'h3: state_next = S_EXEC;
                    4'hF: state_next = S_HALT;
                    4'h0: state_next = S_FETCH;
                    default: begin
                        illegal_op = 1'b1;
                        state_next = S_FETCH;
                    end
                endcase
            end
            S_OPLO: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    pc_count   = 1'b1;
                    lat_lo     = 1'b1;
                    state_next = S_OPHI;
                end
            end
            S_OPHI: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    pc_count   = 1'b1;
                    lat_hi     = 1'b1;
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                state_next = S_FETCH;
                case (op_class)
                    4'h1: begin
                        mem_req  = 1'b1;
                        mem_addr = jump_address;
                        acc_load = mem_ack;
                        if (!mem_ack) state_next = S_EXEC;
                    end
                    4'h2: begin
                        mem_req   = 1'b1;
                        mem_we    = 1'b1;
                        acc_store = 1'b1;
                        mem_addr  = jump_address;
                        if (!mem_ack) state_next = S_EXEC;
                    end
                    4'h3: alu_en  = 1'b1;
                    4'h4: pc_load = 1'b1;
                    4'h5: pc_load = zero_flag;
                    4'h6: pc_load = carry_flag;
                    default: ;
                endcase
            end
            S_HALT: begin
                halted = 1'b1;
                if (resume) state_next = S_FETCH;
            end
            default: state_next = S_RST;
        endcase
        // A stalled bus abandons the access and parks in HALT.
        if (timed_out) state_next = S_HALT;
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed cycle-by-cycle bench for fetch_sequencer with a small
// memory responder and program-counter model.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        clear_n = 1'b0;
    logic [15:0] pc = 16'h0;
    logic [7:0]  mem_rdata = 8'h0;
    logic        resp_ack = 1'b0;
    logic        force_ack = 1'b0;
    wire         mem_ack = resp_ack | force_ack;
    logic        zero_flag = 1'b0;
    logic        carry_flag = 1'b0;
    logic        resume = 1'b0;
    logic        mem_req, mem_we, pc_clear, pc_count, pc_load;
    logic        alu_en, acc_load, acc_store, illegal_op;
    logic        bus_error, halted;
    logic [15:0] mem_addr, jump_address;
    logic [7:0]  opcode;

    int total = 0;
    int bad = 0;
    logic resp_on = 1'b1;
    int delay = 0;
    int wcnt = 0;
    logic [7:0] mem [0:65535];

    localparam logic [8:0] C_CLR  = 9'b1_0000_0000;
    localparam logic [8:0] C_CNT  = 9'b0_1000_0000;
    localparam logic [8:0] C_LD   = 9'b0_0100_0000;
    localparam logic [8:0] C_ALU  = 9'b0_0010_0000;
    localparam logic [8:0] C_ACCL = 9'b0_0001_0000;
    localparam logic [8:0] C_ACCS = 9'b0_0000_1000;
    localparam logic [8:0] C_ILL  = 9'b0_0000_0100;
    localparam logic [8:0] C_BERR = 9'b0_0000_0010;
    localparam logic [8:0] C_HALT = 9'b0_0000_0001;

    wire [8:0] ctl = {pc_clear, pc_count, pc_load, alu_en, acc_load,
                      acc_store, illegal_op, bus_error, halted};

    fetch_sequencer #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .TIMEOUT(4)) dut (
        .clk(clk), .clear_n(clear_n), .pc_address(pc),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .zero_flag(zero_flag), .carry_flag(carry_flag), .resume(resume),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .pc_clear(pc_clear), .pc_count(pc_count), .pc_load(pc_load),
        .jump_address(jump_address), .opcode(opcode), .alu_en(alu_en),
        .acc_load(acc_load), .acc_store(acc_store),
        .illegal_op(illegal_op), .bus_error(bus_error), .halted(halted)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pc_clear) pc <= 16'h0;
        else if (pc_load) pc <= jump_address;
        else if (pc_count) pc <= pc + 16'h1;
    end

    always @(negedge clk) begin
        if (!resp_on || !mem_req) begin
            resp_ack = 1'b0;
            wcnt = 0;
        end else if (wcnt >= delay) begin
            resp_ack = 1'b1;
            mem_rdata = mem[mem_addr];
            wcnt = 0;
        end else begin
            resp_ack = 1'b0;
            wcnt = wcnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input string tag, input logic req, input logic we,
                       input logic [15:0] addr, input logic [8:0] c);
        @(negedge clk);
        #1;
        chk({tag, ".req"}, 32'(mem_req), 32'(req));
        if (req) begin
            chk({tag, ".we"}, 32'(mem_we), 32'(we));
            chk({tag, ".addr"}, 32'(mem_addr), 32'(addr));
        end
        chk({tag, ".ctl"}, 32'(ctl), 32'(c));
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h0001] = 8'h40; mem[16'h0002] = 8'h34; mem[16'h0003] = 8'h12;
        mem[16'h1234] = 8'h50; mem[16'h1235] = 8'h00; mem[16'h1236] = 8'h01;
        mem[16'h1237] = 8'h50; mem[16'h1238] = 8'h00; mem[16'h1239] = 8'h01;
        mem[16'h0100] = 8'h10; mem[16'h0101] = 8'h00; mem[16'h0102] = 8'h20;
        mem[16'h2000] = 8'h5A;
        mem[16'h0103] = 8'h31;
        mem[16'h0104] = 8'h20; mem[16'h0105] = 8'h00; mem[16'h0106] = 8'h30;
        mem[16'h0107] = 8'h7F;
        mem[16'h0108] = 8'hF0;
        mem[16'h0109] = 8'h40; mem[16'h010A] = 8'h22; mem[16'h010B] = 8'h11;

        cyc("rst0", 0, 0, 16'h0, C_CLR);
        cyc("rst1", 0, 0, 16'h0, C_CLR);
        chk("rst.opcode", 32'(opcode), 32'h00);
        clear_n = 1'b1;

        cyc("nop.f", 1, 0, 16'h0000, C_CNT);
        cyc("nop.d", 0, 0, 16'h0, 9'h0);
        chk("nop.opcode", 32'(opcode), 32'h00);

        cyc("jmp.f", 1, 0, 16'h0001, C_CNT);
        cyc("jmp.d", 0, 0, 16'h0, 9'h0);
        chk("jmp.opcode", 32'(opcode), 32'h40);
        cyc("jmp.lo", 1, 0, 16'h0002, C_CNT);
        cyc("jmp.hi", 1, 0, 16'h0003, C_CNT);
        cyc("jmp.x", 0, 0, 16'h0, C_LD);
        chk("jmp.target", 32'(jump_address), 32'h1234);

        cyc("jz0.f", 1, 0, 16'h1234, C_CNT);
        cyc("jz0.d", 0, 0, 16'h0, 9'h0);
        cyc("jz0.lo", 1, 0, 16'h1235, C_CNT);
        cyc("jz0.hi", 1, 0, 16'h1236, C_CNT);
        cyc("jz0.x", 0, 0, 16'h0, 9'h0);
        cyc("jz1.f", 1, 0, 16'h1237, C_CNT);
        zero_flag = 1'b1;
        cyc("jz1.d", 0, 0, 16'h0, 9'h0);
        cyc("jz1.lo", 1, 0, 16'h1238, C_CNT);
        cyc("jz1.hi", 1, 0, 16'h1239, C_CNT);
        cyc("jz1.x", 0, 0, 16'h0, C_LD);

        cyc("lda.f", 1, 0, 16'h0100, C_CNT);
        zero_flag = 1'b0;
        cyc("lda.d", 0, 0, 16'h0, 9'h0);
        cyc("lda.lo", 1, 0, 16'h0101, C_CNT);
        cyc("lda.hi", 1, 0, 16'h0102, C_CNT);
        delay = 3;
        cyc("lda.w1", 1, 0, 16'h2000, 9'h0);
        cyc("lda.w2", 1, 0, 16'h2000, 9'h0);
        cyc("lda.w3", 1, 0, 16'h2000, 9'h0);
        cyc("lda.ack", 1, 0, 16'h2000, C_ACCL);
        delay = 0;

        cyc("alu.f", 1, 0, 16'h0103, C_CNT);
        cyc("alu.d", 0, 0, 16'h0, 9'h0);
        cyc("alu.x", 0, 0, 16'h0, C_ALU);
        chk("alu.op", 32'(opcode[3:0]), 32'h1);

        cyc("sta.f", 1, 0, 16'h0104, C_CNT);
        cyc("sta.d", 0, 0, 16'h0, 9'h0);
        cyc("sta.lo", 1, 0, 16'h0105, C_CNT);
        cyc("sta.hi", 1, 0, 16'h0106, C_CNT);
        cyc("sta.x", 1, 1, 16'h3000, C_ACCS);

        cyc("ill.f", 1, 0, 16'h0107, C_CNT);
        cyc("ill.d", 0, 0, 16'h0, C_ILL);
        cyc("hlt.f", 1, 0, 16'h0108, C_CNT);
        cyc("hlt.d", 0, 0, 16'h0, 9'h0);
        cyc("hlt.h0", 0, 0, 16'h0, C_HALT);
        cyc("hlt.h1", 0, 0, 16'h0, C_HALT);

        resume = 1'b1;
        resp_on = 1'b0;
        cyc("to.w1", 1, 0, 16'h0109, 9'h0);
        resume = 1'b0;
        cyc("to.w2", 1, 0, 16'h0109, 9'h0);
        cyc("to.w3", 1, 0, 16'h0109, 9'h0);
        cyc("to.w4", 1, 0, 16'h0109, 9'h0);
        cyc("to.halt", 0, 0, 16'h0, C_BERR | C_HALT);

        resume = 1'b1;
        resp_on = 1'b1;
        cyc("rs.f", 1, 0, 16'h0109, C_CNT | C_BERR);
        resume = 1'b0;
        cyc("rs.d", 0, 0, 16'h0, C_BERR);
        cyc("rs.lo", 1, 0, 16'h010A, C_CNT | C_BERR);
        resp_on = 1'b0;
        cyc("rs.hi1", 1, 0, 16'h010B, C_BERR);
        cyc("rs.hi2", 1, 0, 16'h010B, C_BERR);
        clear_n = 1'b0;
        force_ack = 1'b1;
        cyc("mr.rst", 0, 0, 16'h0, C_CLR);
        chk("mr.opcode", 32'(opcode), 32'h00);
        chk("mr.jaddr", 32'(jump_address), 32'h0000);
        clear_n = 1'b1;
        force_ack = 1'b0;
        resp_on = 1'b1;
        cyc("mr.f", 1, 0, 16'h0000, C_CNT);
        cyc("mr.d", 0, 0, 16'h0, 9'h0);
        chk("mr.op2", 32'(opcode), 32'h00);
        cyc("mr.f2", 1, 0, 16'h0001, C_CNT);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
